// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder
//
// Purpose:
//   Clocked ripple-carry adder used as the arithmetic core of the 8-bit CPU
//   datapath (ALU add/increment path). Operands and carry-in are sampled on
//   the rising clock edge. The sum and carry-out come from output registers
//   one cycle later. A new result is loaded every cycle, with no enable.
//
// Optional feature (macro ADDER_FLAGS_EN):
//   When ADDER_FLAGS_EN is defined, registered signed-overflow and zero
//   flags are added for the CPU status register. When it is undefined, those
//   ports and registers do not exist, and Sum/Carry_out behave the same.
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous active-high reset (has priority)
//   A          in   WIDTH  operand A (two's complement when flags are used)
//   B          in   WIDTH  operand B
//   Carry_in   in   1      carry into bit 0
//   Sum        out  WIDTH  registered (A + B + Carry_in) mod 2^WIDTH
//   Carry_out  out  1      registered carry out of bit WIDTH-1
//   Overflow   out  1      registered signed overflow  (ADDER_FLAGS_EN only)
//   Zero       out  1      registered sum-is-zero flag (ADDER_FLAGS_EN only)
// ---------------------------------------------------------------------------
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out
`ifdef ADDER_FLAGS_EN
    ,
    output logic             Overflow,
    output logic             Zero
`endif
);

    // The carry chain. carry[i] is the carry into bit i and carry[WIDTH] is
    // the carry out of the top bit.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = Carry_in;

    // Full-adder chain. The clock period must cover the ripple through all
    // WIDTH stages.
    for (genvar i = 0; i < WIDTH; i++) begin : g_full_adder
        assign sum_bits[i]  = A[i] ^ B[i] ^ carry[i];
        assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    logic [WIDTH-1:0] sum_d,       sum_q;
    logic             carry_out_d, carry_out_q;

    // Next-state values for the result registers. Reset is applied in the
    // register process so that it always overrides the arithmetic result.
    always_comb begin
        sum_d       = sum_bits;
        carry_out_d = carry[WIDTH];
    end

    // Result registers. An operation sampled on a reset edge is dropped and
    // is not replayed later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign Sum       = sum_q;
    assign Carry_out = carry_out_q;

`ifdef ADDER_FLAGS_EN
    logic overflow_d, overflow_q;
    logic zero_d,     zero_q;

    // Signed overflow is set when the carries into and out of the sign bit
    // differ. Zero looks only at the sum bits, so a carry-out of 1 with an
    // all-zero sum still reports zero.
    always_comb begin
        overflow_d = carry[WIDTH] ^ carry[WIDTH-1];
        zero_d     = ~|sum_bits;
    end

    // Flag registers. Zero resets to 0 as a fixed value. It is not derived
    // from the cleared sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign Overflow = overflow_q;
    assign Zero     = zero_q;
`endif

endmodule

// File: tb/tb_adder.sv
// ---------------------------------------------------------------------------
// tb_adder
//
// Directed and random checks for the clocked adder. Inputs change on the
// falling edge. The DUT samples them on the next rising edge, and outputs
// are compared on the falling edge that follows. Flag checks are compiled
// in only when ADDER_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_adder;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
`ifdef ADDER_FLAGS_EN
    logic       ovf;
    logic       zero;
`endif

    int checkCount;
    int passCount;

    adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .Carry_in  (cin),
        .Sum       (sum),
        .Carry_out (cout)
`ifdef ADDER_FLAGS_EN
        ,
        .Overflow  (ovf),
        .Zero      (zero)
`endif
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let the DUT sample it on the rising edge, and
    // return on the following falling edge when the result is stable.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic rv);
        a   = av;
        b   = bv;
        cin = cv;
        rst = rv;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare the registered result with hand-computed or model values.
    // In the flag build the flags are compared too.
    task automatic checkOutput(input string tag, input logic [7:0] expSum,
                               input logic expCout, input logic expOvf,
                               input logic expZero);
        checkCount++;
        assert (sum === expSum) passCount++;
        else $error("[TB] FAIL %s sum: got %0d expected %0d", tag, sum, expSum);
        checkCount++;
        assert (cout === expCout) passCount++;
        else $error("[TB] FAIL %s cout: got %0b expected %0b", tag, cout, expCout);
`ifdef ADDER_FLAGS_EN
        checkCount++;
        assert (ovf === expOvf) passCount++;
        else $error("[TB] FAIL %s ovf: got %0b expected %0b", tag, ovf, expOvf);
        checkCount++;
        assert (zero === expZero) passCount++;
        else $error("[TB] FAIL %s zero: got %0b expected %0b", tag, zero, expZero);
`else
        if (expOvf === 1'bx || expZero === 1'bx) begin
            $display("[TB] note: unexpected unknown flag expectation in %s", tag);
        end
`endif
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] full;
        logic       refOvf;

        checkCount = 0;
        passCount  = 0;
        a   = 8'h00;
        b   = 8'h00;
        cin = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Reset wins over inputs that would give the largest possible sum.
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
        checkOutput("reset1", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
        checkOutput("reset2", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
        checkOutput("release", 8'd255, 1'b1, 1'b0, 1'b0);

        // No carry out.
        applyStimulus(8'hB0, 8'h48, 1'b0, 1'b0);
        checkOutput("nocarry1", 8'd248, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hC0, 8'h28, 1'b1, 1'b0);
        checkOutput("nocarry2", 8'd233, 1'b0, 1'b0, 1'b0);

        // Carry out, applied back-to-back on successive edges.
        applyStimulus(8'h88, 8'hC8, 1'b0, 1'b0);
        checkOutput("carry1", 8'd80, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'hF0, 8'hD0, 1'b0, 1'b0);
        checkOutput("carry2", 8'd192, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h97, 8'hD8, 1'b1, 1'b0);
        checkOutput("carry3", 8'd112, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'hAC, 8'hFA, 1'b1, 1'b0);
        checkOutput("carry4", 8'd167, 1'b1, 1'b0, 1'b0);

        // Carry-in ripples the full width. Zero ignores the carry-out.
        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
        checkOutput("ripplezero", 8'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h7F, 8'h00, 1'b1, 1'b0);
        checkOutput("rippleovf", 8'd128, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset drops the operation sampled on that edge.
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
        checkOutput("midreset", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
        checkOutput("afterreset", 8'd48, 1'b0, 1'b0, 1'b0);

        // Random operands against an arithmetic reference model.
        for (int i = 0; i < 1000; i++) begin
            ra     = 8'($urandom_range(0, 255));
            rb     = 8'($urandom_range(0, 255));
            rc     = 1'($urandom_range(0, 1));
            full   = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            refOvf = (ra[7] == rb[7]) && (full[7] != ra[7]);
            applyStimulus(ra, rb, rc, 1'b0);
            checkOutput("random", full[7:0], full[8], refOvf, full[7:0] == 8'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
